// File: rtl/a2d_arbiter.sv
// Two-requester arbiter in front of a single SPI A2D engine: fair grant,
// start/complete handshake, timeout abort, result returned with a done pulse.
module a2d_arbiter #(
   parameter int TIMEOUT = 4096,
   parameter int CH_W    = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0,
   input  logic [CH_W-1:0] chnnl0,
   input  logic            req1,
   input  logic [CH_W-1:0] chnnl1,
   output logic            done0,
   output logic            done1,
   output logic            err,
   output logic [11:0]     res,
   output logic            busy,
   output logic            a2d_strt,
   output logic [CH_W-1:0] a2d_chnnl,
   input  logic            a2d_cmplt,
   input  logic [11:0]     a2d_res
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t            state_reg, state_next;
   logic              owner_reg, owner_next;
   logic              last_reg, last_next;
   logic [TW-1:0]     timer_reg, timer_next;
   logic [CH_W-1:0]   chnnl_reg, chnnl_next;
   logic [11:0]       res_reg, res_next;
   logic              strt_reg, strt_next;
   logic              done0_reg, done0_next;
   logic              done1_reg, done1_next;
   logic              err_reg, err_next;
   logic              busy_reg, busy_next;
   logic              grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         owner_reg <= 1'b0;
         last_reg  <= 1'b1;   // requester 0 wins the first tie
         timer_reg <= '0;
         chnnl_reg <= '0;
         res_reg   <= '0;
         strt_reg  <= 1'b0;
         done0_reg <= 1'b0;
         done1_reg <= 1'b0;
         err_reg   <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         owner_reg <= owner_next;
         last_reg  <= last_next;
         timer_reg <= timer_next;
         chnnl_reg <= chnnl_next;
         res_reg   <= res_next;
         strt_reg  <= strt_next;
         done0_reg <= done0_next;
         done1_reg <= done1_next;
         err_reg   <= err_next;
         busy_reg  <= busy_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      owner_next = owner_reg;
      last_next  = last_reg;
      timer_next = timer_reg;
      chnnl_next = chnnl_reg;
      res_next   = res_reg;
      strt_next  = 1'b0;
      done0_next = 1'b0;
      done1_next = 1'b0;
      err_next   = 1'b0;
      grant      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req0 || req1) begin
               grant      = (req0 && req1) ? ~last_reg : req1;
               owner_next = grant;
               chnnl_next = grant ? chnnl1 : chnnl0;
               strt_next  = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            timer_next = '0;
            state_next = WAIT;
         end
         WAIT: begin
            // A completion arriving on the timeout cycle still counts as good.
            if (a2d_cmplt) begin
               res_next   = a2d_res;
               done0_next = ~owner_reg;
               done1_next = owner_reg;
               state_next = DONE;
            end else if (timer_reg == TW'(TIMEOUT - 1)) begin
               res_next   = 12'h000;
               done0_next = ~owner_reg;
               done1_next = owner_reg;
               err_next   = 1'b1;
               state_next = DONE;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         DONE: begin
            last_next  = owner_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next != IDLE);
   end

   assign done0     = done0_reg;
   assign done1     = done1_reg;
   assign err       = err_reg;
   assign res       = res_reg;
   assign busy      = busy_reg;
   assign a2d_strt  = strt_reg;
   assign a2d_chnnl = chnnl_reg;

endmodule
